// File: rtl/ccu_snoop_ctrl.sv
// Snoop engine: broadcasts one snoop command on AC to a masked subset of
// master ports, merges their CR responses into one result, forwards CD data
// from the lowest-index data responder and drains CD from the other ones.
module ccu_snoop_ctrl #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [3:0]                      req_snoop_i,
  input  logic [2:0]                      req_prot_i,
  input  logic [NoMstPorts-1:0]           req_mask_i,
  output logic [NoMstPorts-1:0]           ac_valid_o,
  input  logic [NoMstPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output logic [3:0]                      ac_snoop_o,
  output logic [2:0]                      ac_prot_o,
  input  logic [NoMstPorts-1:0]           cr_valid_i,
  output logic [NoMstPorts-1:0]           cr_ready_o,
  input  logic [5*NoMstPorts-1:0]         cr_resp_i,
  input  logic [NoMstPorts-1:0]           cd_valid_i,
  output logic [NoMstPorts-1:0]           cd_ready_o,
  input  logic [DataWidth*NoMstPorts-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]           cd_last_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic                            rsp_data_o,
  output logic                            rsp_dirty_o,
  output logic                            rsp_shared_o,
  output logic                            rsp_unique_o,
  output logic                            rsp_error_o,
  output logic                            data_valid_o,
  input  logic                            data_ready_i,
  output logic [DataWidth-1:0]            data_o,
  output logic                            data_last_o
);

  localparam int unsigned SelW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_RESP, ST_DATA} state_e;

  state_e                     r_state, w_state_nxt;
  logic [AddrWidth-1:0]       r_addr;
  logic [3:0]                 r_snoop;
  logic [2:0]                 r_prot;
  logic [NoMstPorts-1:0]      r_mask;
  logic [NoMstPorts-1:0]      r_ac_done, r_cr_done, r_cd_done;
  logic [NoMstPorts-1:0][4:0] r_resp;
  logic [SelW-1:0]            r_sel, w_sel_nxt;

  logic [NoMstPorts-1:0]      w_ac_valid, w_cr_ready, w_cd_ready;
  logic [NoMstPorts-1:0]      w_ac_hs, w_cr_hs, w_cd_last_hs, w_dt;
  logic [4:0]                 w_resp_or;
  logic                       w_fwd_valid, w_fwd_last;
  logic [DataWidth-1:0]       w_fwd_data;

  assign w_ac_valid   = (r_state == ST_SNOOP) ? (r_mask & ~r_ac_done) : '0;
  // CR is only offered to ports whose own AC handshake has completed.
  assign w_cr_ready   = (r_state == ST_SNOOP) ? (r_mask & r_ac_done & ~r_cr_done) : '0;
  assign w_ac_hs      = w_ac_valid & ac_ready_i;
  assign w_cr_hs      = w_cr_ready & cr_valid_i;
  assign w_cd_last_hs = w_cd_ready & cd_valid_i & cd_last_i;

  always_comb begin
    w_resp_or = '0;
    w_dt      = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      w_resp_or = w_resp_or | r_resp[i];
      w_dt[i]   = r_mask[i] & r_resp[i][0];
    end
  end

  always_comb begin
    w_sel_nxt = '0;
    for (int unsigned i = NoMstPorts; i > 0; i--) begin
      if (w_dt[i-1]) w_sel_nxt = SelW'(i-1);
    end
  end

  // Selected port is passed through; other data responders are drained.
  always_comb begin
    w_fwd_valid = 1'b0;
    w_fwd_last  = 1'b0;
    w_fwd_data  = '0;
    w_cd_ready  = '0;
    if (r_state == ST_DATA) begin
      for (int unsigned i = 0; i < NoMstPorts; i++) begin
        if (r_sel == SelW'(i)) begin
          w_fwd_valid   = cd_valid_i[i] & ~r_cd_done[i];
          w_fwd_last    = cd_last_i[i];
          w_fwd_data    = cd_data_i[i*DataWidth +: DataWidth];
          w_cd_ready[i] = data_ready_i & ~r_cd_done[i];
        end else begin
          w_cd_ready[i] = w_dt[i] & ~r_cd_done[i];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) w_state_nxt = (req_mask_i != '0) ? ST_SNOOP : ST_RESP;
      end
      ST_SNOOP: begin
        if ((r_cr_done | w_cr_hs) == r_mask) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) w_state_nxt = (w_dt != '0) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (((r_cd_done | w_cd_last_hs) & w_dt) == w_dt) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_snoop   <= '0;
      r_prot    <= '0;
      r_mask    <= '0;
      r_ac_done <= '0;
      r_cr_done <= '0;
      r_cd_done <= '0;
      r_resp    <= '0;
      r_sel     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && req_valid_i) begin
        r_addr  <= req_addr_i;
        r_snoop <= req_snoop_i;
        r_prot  <= req_prot_i;
        r_mask  <= req_mask_i;
      end
      if (w_state_nxt == ST_IDLE) begin
        r_ac_done <= '0;
        r_cr_done <= '0;
        r_cd_done <= '0;
        r_resp    <= '0;
        r_sel     <= '0;
      end else begin
        r_ac_done <= r_ac_done | w_ac_hs;
        r_cr_done <= r_cr_done | w_cr_hs;
        r_cd_done <= r_cd_done | w_cd_last_hs;
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
          if (w_cr_hs[i]) r_resp[i] <= cr_resp_i[5*i +: 5];
        end
        if (r_state == ST_RESP) r_sel <= w_sel_nxt;
      end
    end
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign ac_valid_o   = w_ac_valid;
  assign ac_addr_o    = r_addr;
  assign ac_snoop_o   = r_snoop;
  assign ac_prot_o    = r_prot;
  assign cr_ready_o   = w_cr_ready;
  assign cd_ready_o   = w_cd_ready;
  assign rsp_valid_o  = (r_state == ST_RESP);
  assign rsp_data_o   = rsp_valid_o & w_resp_or[0];
  assign rsp_error_o  = rsp_valid_o & w_resp_or[1];
  assign rsp_dirty_o  = rsp_valid_o & w_resp_or[2];
  assign rsp_shared_o = rsp_valid_o & w_resp_or[3];
  assign rsp_unique_o = rsp_valid_o & w_resp_or[4];
  assign data_valid_o = w_fwd_valid;
  assign data_o       = w_fwd_data;
  assign data_last_o  = w_fwd_last;

endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
module tb_ccu_snoop_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam logic [AW-1:0] ADDR = 64'h0000_1234_5678_9AC0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_addr;
  logic [3:0]      req_snoop;
  logic [2:0]      req_prot;
  logic [N-1:0]    req_mask;
  logic [N-1:0]    ac_valid, ac_ready;
  logic [AW-1:0]   ac_addr;
  logic [3:0]      ac_snoop;
  logic [2:0]      ac_prot;
  logic [N-1:0]    cr_valid, cr_ready;
  logic [5*N-1:0]  cr_resp;
  logic [N-1:0]    cd_valid, cd_ready, cd_last;
  logic [DW*N-1:0] cd_data;
  logic            rsp_valid, rsp_ready;
  logic            rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error;
  logic            data_valid, data_ready, data_last;
  logic [DW-1:0]   data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ccu_snoop_ctrl #(.NoMstPorts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_snoop_i(req_snoop), .req_prot_i(req_prot), .req_mask_i(req_mask),
    .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr),
    .ac_snoop_o(ac_snoop), .ac_prot_o(ac_prot),
    .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
    .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_dirty_o(rsp_dirty), .rsp_shared_o(rsp_shared),
    .rsp_unique_o(rsp_unique), .rsp_error_o(rsp_error),
    .data_valid_o(data_valid), .data_ready_i(data_ready),
    .data_o(data_out), .data_last_o(data_last)
  );

  task automatic clear_inputs();
    req_valid = 0; req_addr = '0; req_snoop = '0; req_prot = '0; req_mask = '0;
    ac_ready = '0; cr_valid = '0; cr_resp = '0;
    cd_valid = '0; cd_data = '0; cd_last = '0;
    rsp_ready = 0; data_ready = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives cycles 0..2 of a command with every port ready; returns in cycle 2.
  task automatic cmd_through_cr(input logic [N-1:0] mask, input logic [5*N-1:0] resp);
    tick();
    req_valid = 1; req_addr = ADDR; req_snoop = 4'h7; req_prot = 3'h5; req_mask = mask;
    ac_ready = '1; cr_valid = '1; cr_resp = resp;
    tick();
    req_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if ({ac_valid, cr_ready, cd_ready} !== '0) begin
      failures++; $display("FAIL reset_handshakes got=%b exp=0", {ac_valid, cr_ready, cd_ready});
    end
    checks++;
    if ({rsp_valid, data_valid, data_last, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error} !== 8'h00) begin
      failures++; $display("FAIL reset_rsp got=%b exp=0",
        {rsp_valid, data_valid, data_last, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error});
    end
    checks++;
    if ({ac_addr, ac_snoop, ac_prot, data_out} !== '0) begin
      failures++; $display("FAIL reset_payload got=%h exp=0", {ac_addr, ac_snoop, ac_prot, data_out});
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_no_data();
    tick();
    req_valid = 1; req_addr = ADDR; req_snoop = 4'h1; req_prot = 3'h2; req_mask = 4'b1110;
    ac_ready = '1; cr_valid = '1; cr_resp = '0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL nodata_accept got=%b exp=1", req_ready);
    end
    tick(); req_valid = 0; #1;
    checks++;
    if (ac_valid !== 4'b1110 || cr_ready !== 4'b0000) begin
      failures++; $display("FAIL nodata_c1 ac_valid=%b cr_ready=%b exp=1110/0000", ac_valid, cr_ready);
    end
    checks++;
    if (ac_addr !== ADDR || ac_snoop !== 4'h1 || ac_prot !== 3'h2) begin
      failures++; $display("FAIL nodata_payload got=%h/%h/%h exp=%h/1/2", ac_addr, ac_snoop, ac_prot, ADDR);
    end
    tick(); #1;
    checks++;
    if (ac_valid !== 4'b0000 || cr_ready !== 4'b1110 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL nodata_c2 ac_valid=%b cr_ready=%b rsp=%b exp=0000/1110/0", ac_valid, cr_ready, rsp_valid);
    end
    tick(); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error} !== 6'b100000) begin
      failures++; $display("FAIL nodata_rsp got=%b exp=100000",
        {rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error});
    end
    rsp_ready = 1;
    tick(); rsp_ready = 0; #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || data_valid !== 1'b0) begin
      failures++; $display("FAIL nodata_idle req_ready=%b rsp=%b dv=%b exp=1/0/0", req_ready, rsp_valid, data_valid);
    end
    clear_inputs();
  endtask

  task automatic test_stagger();
    logic [3:0] exp_ac [9];
    logic [3:0] exp_cr [9];
    exp_ac = '{4'b1111, 4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    exp_cr = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    tick();
    req_valid = 1; req_addr = ADDR; req_mask = 4'b1111; cr_valid = '1; cr_resp = '0; ac_ready = '0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      req_valid = 0;
      ac_ready = ((c % 2) == 1 && c <= 7) ? (4'b0001 << ((c - 1) / 2)) : 4'b0000;
      #1;
      checks++;
      if (ac_valid !== exp_ac[c-1] || cr_ready !== exp_cr[c-1] || rsp_valid !== (c == 9)) begin
        failures++;
        $display("FAIL stagger_c%0d ac_valid=%b cr_ready=%b rsp=%b exp=%b/%b/%b",
                 c, ac_valid, cr_ready, rsp_valid, exp_ac[c-1], exp_cr[c-1], (c == 9));
      end
    end
    rsp_ready = 1;
    tick(); rsp_ready = 0; #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL stagger_idle got=%b exp=1", req_ready);
    end
    clear_inputs();
  endtask

  task automatic test_data_forward();
    logic [DW-1:0] d1, d3;
    // p3: DT+PassDirty, p2: IsShared, p1: DT, p0: WasUnique
    cmd_through_cr(4'b1111, {5'b00101, 5'b01000, 5'b00001, 5'b10000});
    cd_valid = '1; #1;
    checks++;
    if (cd_ready !== 4'b0000 || cr_ready !== 4'b1111) begin
      failures++; $display("FAIL fwd_snoop_cd cd_ready=%b cr_ready=%b exp=0000/1111", cd_ready, cr_ready);
    end
    tick(); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error} !== 6'b111110) begin
      failures++; $display("FAIL fwd_rsp got=%b exp=111110",
        {rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error});
    end
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      rsp_ready = 0; data_ready = 1;
      d1 = 64'h1111_0000_0000_0000 + 64'(k);
      d3 = 64'h3333_0000_0000_0000 + 64'(k);
      cd_data = {d3, 64'hDEAD_0002, d1, 64'hDEAD_0000};
      cd_last = (k == 3) ? 4'b1010 : 4'b0000;
      #1;
      checks++;
      if (data_valid !== 1'b1 || data_out !== d1 || data_last !== (k == 3) || cd_ready !== 4'b1010) begin
        failures++;
        $display("FAIL fwd_beat%0d dv=%b data=%h last=%b cd_ready=%b exp=1/%h/%b/1010",
                 k, data_valid, data_out, data_last, cd_ready, d1, (k == 3));
      end
    end
    tick(); #1;
    checks++;
    if (req_ready !== 1'b1 || cd_ready !== 4'b0000 || data_valid !== 1'b0) begin
      failures++; $display("FAIL fwd_idle req_ready=%b cd_ready=%b dv=%b exp=1/0000/0", req_ready, cd_ready, data_valid);
    end
    clear_inputs();
  endtask

  task automatic test_mask_zero();
    tick();
    req_valid = 1; req_addr = ADDR; req_mask = 4'b0000;
    tick(); req_valid = 0; #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error} !== 6'b100000 || ac_valid !== 4'b0000) begin
      failures++; $display("FAIL mask0_rsp rsp=%b ac_valid=%b exp=100000/0000",
        {rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error}, ac_valid);
    end
    rsp_ready = 1;
    tick(); rsp_ready = 0; #1;
    checks++;
    if (req_ready !== 1'b1 || ac_valid !== 4'b0000) begin
      failures++; $display("FAIL mask0_idle req_ready=%b ac_valid=%b exp=1/0000", req_ready, ac_valid);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int b;
    logic dr;
    logic [DW-1:0] d0;
    b = 0;
    // p0: DT, p1: Error only
    cmd_through_cr(4'b0011, {5'b00000, 5'b00000, 5'b00010, 5'b00001});
    tick(); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error} !== 6'b110001) begin
      failures++; $display("FAIL bp_rsp got=%b exp=110001",
        {rsp_valid, rsp_data, rsp_dirty, rsp_shared, rsp_unique, rsp_error});
    end
    rsp_ready = 1;
    for (int c = 0; c < 7; c++) begin
      tick();
      rsp_ready = 0;
      dr = ((c % 2) == 0);
      data_ready = dr;
      d0 = 64'hC0C0_0000_0000_0000 + 64'(b);
      cd_valid = 4'b0011;
      cd_data = {64'h0, 64'h0, 64'hBAD1, d0};
      cd_last = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (cd_ready !== {3'b000, dr} || data_valid !== 1'b1 || data_out !== d0 || data_last !== (b == 3)) begin
        failures++;
        $display("FAIL bp_c%0d cd_ready=%b dv=%b data=%h last=%b exp=%b/1/%h/%b",
                 c, cd_ready, data_valid, data_out, data_last, {3'b000, dr}, d0, (b == 3));
      end
      if (dr) b++;
    end
    tick(); #1;
    checks++;
    if (req_ready !== 1'b1 || cd_ready !== 4'b0000) begin
      failures++; $display("FAIL bp_idle req_ready=%b cd_ready=%b exp=1/0000", req_ready, cd_ready);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 1; req_addr = ADDR; req_mask = 4'b1111; ac_ready = '0;
    tick(); req_valid = 0; #1;
    checks++;
    if (ac_valid !== 4'b1111) begin
      failures++; $display("FAIL rst_snoop_pre got=%b exp=1111", ac_valid);
    end
    tick();
    rst_n = 0; #1;
    checks++;
    if (req_ready !== 1'b1 || ac_valid !== 4'b0000 || cr_ready !== 4'b0000 || ac_addr !== '0) begin
      failures++; $display("FAIL rst_snoop req_ready=%b ac_valid=%b cr_ready=%b addr=%h exp=1/0000/0000/0",
        req_ready, ac_valid, cr_ready, ac_addr);
    end
    tick(); rst_n = 1;
    clear_inputs();
    test_no_data();

    cmd_through_cr(4'b0101, {5'b00000, 5'b00001, 5'b00000, 5'b00001});
    tick(); rsp_ready = 1;
    tick(); rsp_ready = 0; cd_valid = 4'b0101; data_ready = 1; #1;
    checks++;
    if (cd_ready !== 4'b0101 || data_valid !== 1'b1) begin
      failures++; $display("FAIL rst_data_pre cd_ready=%b dv=%b exp=0101/1", cd_ready, data_valid);
    end
    rst_n = 0; #1;
    checks++;
    if (req_ready !== 1'b1 || cd_ready !== 4'b0000 || data_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_data req_ready=%b cd_ready=%b dv=%b rsp=%b exp=1/0000/0/0",
        req_ready, cd_ready, data_valid, rsp_valid);
    end
    tick(); rst_n = 1;
    clear_inputs();
    test_mask_zero();
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_stagger();
    test_data_forward();
    test_mask_zero();
    test_backpressure();
    test_reset_mid();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
